seq_lock_ctrl: RTL

SEQ_LOCK_CTRL -- requirements
Module: seq_lock_ctrl

---
 rtl/seq_lock_pkg.sv | 24 ++
 rtl/seq_detect_1100.sv | 38 +++
 rtl/seq_lock_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seq_lock_pkg.sv
// Shared types and default constants for the sequence lock controller.
// Defines detector and controller state encodings.
package seq_lock_pkg;

  localparam int unsigned DefDbCycles   = 4;
  localparam int unsigned DefLockCycles = 16;
  localparam int unsigned DefMaxFail    = 3;

  typedef enum logic [2:0] {
    DetS0 = 3'd0,
    DetS1 = 3'd1,
    DetS2 = 3'd2,
    DetS3 = 3'd3,
    DetS4 = 3'd4
  } det_state_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StEntry   = 2'd1,
    StOpen    = 2'd2,
    StLockout = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/seq_detect_1100.sv
// Moore detector for the symbol sequence 1,1,0,0; hit is high in state S4.
// clr restarts from S0 before the same-cycle symbol is applied.
module seq_detect_1100
  import seq_lock_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic sym_valid,
  input  logic sym,
  output logic hit
);

  det_state_e state_q, state_d, base;

  always_comb begin
    base    = clr ? DetS0 : state_q;
    state_d = base;
    if (sym_valid) begin
      unique case (base)
        DetS0:   state_d = sym ? DetS1 : DetS0;
        DetS1:   state_d = sym ? DetS2 : DetS0;
        DetS2:   state_d = sym ? DetS2 : DetS3;
        DetS3:   state_d = sym ? DetS1 : DetS4;
        DetS4:   state_d = sym ? DetS1 : DetS0;
        default: state_d = DetS0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= DetS0;
    else        state_q <= state_d;
  end

  assign hit = (state_q == DetS4);

endmodule

// File: rtl/seq_lock_ctrl.sv
// Two-button sequence lock: sync/debounce, symbol arbitration, attempt FSM.
// Lockout state and its timer exist only when SEQ_LOCK_LOCKOUT_EN is defined.
module seq_lock_ctrl
  import seq_lock_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DefDbCycles,
  parameter int unsigned LOCK_CYCLES = DefLockCycles,
  parameter int unsigned MAX_FAIL    = DefMaxFail
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       P1,
  input  logic       P2,
  output logic       sym_valid,
  output logic       sym,
  output logic       unlock,
  output logic       locked_out,
  output logic [1:0] fail_cnt
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  if (MAX_FAIL < 1 || MAX_FAIL > 3 || LOCK_CYCLES < 1) begin : g_bad_cfg
    $error("seq_lock_ctrl: MAX_FAIL must be 1..3 and LOCK_CYCLES >= 1");
  end

  // Bit 0 carries P1, bit 1 carries P2.
  logic [1:0]      sync1_q, sync2_q, db_q, db_dly_q, ev_q;
  logic [CntW-1:0] db_cnt_q [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      ev_q     <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= {P2, P1};
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      ev_q     <= db_q & ~db_dly_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CntW'(DB_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  ctrl_state_e state_q, state_d;
  logic [2:0]  sym_cnt_q, sym_cnt_d;
  logic [1:0]  fail_q, fail_d, fail_inc;
  logic        pend_q, pend_d, sv_q, sv_d, sym_q, sym_d;
  logic        discard, hit, det_clr;

  // P1 wins a tie; a simultaneous P2 waits one cycle in the pending slot.
  always_comb begin
    sv_d   = 1'b0;
    sym_d  = 1'b0;
    pend_d = pend_q;
    if (discard) begin
      pend_d = 1'b0;
    end else if (ev_q[0]) begin
      sv_d  = 1'b1;
      sym_d = 1'b1;
      if (ev_q[1] && !pend_q) pend_d = 1'b1;
    end else if (pend_q) begin
      sv_d   = 1'b1;
      pend_d = 1'b0;
    end else if (ev_q[1]) begin
      sv_d = 1'b1;
    end
  end

  // The detector consumes symbols one cycle ahead of the FSM, so hit already
  // reflects the 4th symbol when the FSM sees that symbol on sv_q.
  assign det_clr = sv_d && ((state_d == StIdle) || (state_d == StOpen));

  seq_detect_1100 u_detect (
    .clk       (clk),
    .reset     (reset),
    .clr       (det_clr),
    .sym_valid (sv_d),
    .sym       (sym_d),
    .hit       (hit)
  );

  assign fail_inc = fail_q + 2'd1;

`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  assign discard = (state_q == StLockout) || (state_d == StLockout);
`else
  assign discard = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    fail_d    = fail_q;
`ifdef SEQ_LOCK_LOCKOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      StIdle, StOpen: begin
        if (sv_q) begin
          state_d   = StEntry;
          sym_cnt_d = 3'd1;
        end
      end
      StEntry: begin
        if (sv_q) begin
          sym_cnt_d = sym_cnt_q + 3'd1;
          if (sym_cnt_q == 3'd3) begin
            if (hit) begin
              state_d = StOpen;
              fail_d  = 2'd0;
            end else begin
`ifdef SEQ_LOCK_LOCKOUT_EN
              fail_d     = fail_inc;
              lock_cnt_d = '0;
              state_d    = (fail_inc == 2'(MAX_FAIL)) ? StLockout : StIdle;
`else
              fail_d  = (fail_q == 2'd3) ? 2'd3 : fail_inc;
              state_d = StIdle;
`endif
            end
          end
        end
      end
      StLockout: begin
`ifdef SEQ_LOCK_LOCKOUT_EN
        if (lock_cnt_q == LockW'(LOCK_CYCLES - 1)) begin
          state_d    = StIdle;
          fail_d     = 2'd0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sym_cnt_q <= '0;
      fail_q    <= '0;
      pend_q    <= 1'b0;
      sv_q      <= 1'b0;
      sym_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      fail_q    <= fail_d;
      pend_q    <= pend_d;
      sv_q      <= sv_d;
      sym_q     <= sym_d;
    end
  end

`ifdef SEQ_LOCK_LOCKOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lock_cnt_q <= '0;
    else        lock_cnt_q <= lock_cnt_d;
  end
  assign locked_out = (state_q == StLockout);
`else
  assign locked_out = 1'b0;
`endif

  assign sym_valid = sv_q;
  assign sym       = sym_q;
  assign unlock    = (state_q == StOpen);
  assign fail_cnt  = fail_q;

endmodule
